// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, WIDTH iterations.
// Optional feature macro: MDU_EARLY_TERM_EN (multiply exits RUN once the remaining multiplier bits are zero).
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       MDcon,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZ,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is accepted on a rising edge where start=1 and busy=0.
  // busy stays high from the next cycle through the done cycle; done is a one-cycle
  // pulse during which Hi/Lo/DivZ carry the result. Requests while busy are dropped.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_res;
  logic              neg_rem;
  logic              divz;
  logic [WIDTH-1:0]  acc_hi, acc_lo;
  logic [WIDTH-1:0]  opnd;
  logic [WIDTH-1:0]  mpl;
  logic [WIDTH-1:0]  hi_q, lo_q;

  logic              op_signed;
  logic              div_zero_req;
  logic [WIDTH-1:0]  abs_a, abs_b;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  mul_hi_nxt, mul_lo_nxt;

  logic [WIDTH:0]    rem_sh;
  logic              div_ge;
  logic [WIDTH-1:0]  div_hi_nxt, div_lo_nxt;

  logic              mul_early;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  res_hi, res_lo;

  // Operand conditioning at accept
  always_comb begin
    op_signed    = ~MDcon[0];
    div_zero_req = MDcon[1] && (SrcB == '0);
    abs_a        = (op_signed && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
    abs_b        = (op_signed && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;
  end

  // One multiply step: conditionally add multiplicand into the upper half, shift right.
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (mpl[0] ? {1'b0, opnd} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // One restoring divide step: acc_hi is the partial remainder, acc_lo the dividend/quotient.
  always_comb begin
    rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
    div_ge     = rem_sh >= {1'b0, opnd};
    div_hi_nxt = div_ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
    div_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
  end

`ifdef MDU_EARLY_TERM_EN
  assign mul_early = ~is_div && (mpl[WIDTH-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  // Final correction applied during FIX
  always_comb begin
`ifdef MDU_EARLY_TERM_EN
    // Any iterations skipped by early exit are pure right shifts.
    prod = {acc_hi, acc_lo} >> cnt;
`else
    prod = {acc_hi, acc_lo};
`endif
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (divz) begin
      res_hi = acc_hi;
      res_lo = acc_lo;
    end else if (is_div) begin
      res_hi = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
      res_lo = neg_res ? (~acc_lo + 1'b1) : acc_lo;
    end else if (neg_res) begin
      {res_hi, res_lo} = ~prod + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = div_zero_req ? FIX : RUN;
      RUN:  if (cnt == CW'(1) || mul_early) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      divz    <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      mpl     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= CW'(WIDTH);
            is_div  <= MDcon[1];
            neg_res <= op_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_rem <= op_signed && SrcA[WIDTH-1];
            divz    <= div_zero_req;
            if (div_zero_req) begin
              acc_hi <= SrcA;
              acc_lo <= '1;
            end else if (MDcon[1]) begin
              acc_hi <= '0;
              acc_lo <= abs_a;
              opnd   <= abs_b;
            end else begin
              acc_hi <= '0;
              acc_lo <= '0;
              opnd   <= abs_a;
              mpl    <= abs_b;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc_hi <= div_hi_nxt;
            acc_lo <= div_lo_nxt;
          end else begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
            mpl    <= mpl >> 1;
          end
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIX);
    Hi        = done ? res_hi : hi_q;
    Lo        = done ? res_lo : lo_q;
    DivZ      = divz;
    dbg_state = state;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed and random ops checked against a 64-bit arithmetic reference model.
module tb_mdu_seq;
  localparam int W  = 32;
  localparam int RW = 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   MDcon = 2'b00;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         busy, done, DivZ;
  logic [W-1:0] Hi, Lo;
  logic [1:0]   state_obs;

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] exp_q[$];

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MDcon(MDcon),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .Hi(Hi), .Lo(Lo), .DivZ(DivZ), .dbg_state(state_obs)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic plus expected done latency.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [RW-1:0] r, output int lat, output bit dz);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, uq, urm;
    logic [W-1:0] mb;
    int runs;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    lat = W + 1;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == '0) begin
          r = {a, 32'hFFFF_FFFF}; dz = 1'b1; lat = 1;
        end else begin
          q = sa / sb; rm = sa % sb;
          r = {rm[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) begin
          r = {a, 32'hFFFF_FFFF}; dz = 1'b1; lat = 1;
        end else begin
          uq = ua / ub; urm = ua % ub;
          r = {urm[31:0], uq[31:0]};
        end
      end
    endcase
`ifdef MDU_EARLY_TERM_EN
    if (op[1] == 1'b0) begin
      mb = (op == 2'b00 && b[W-1]) ? -b : b;
      runs = 1;
      for (int i = 0; i < W; i++) if (mb[i]) runs = i + 1;
      lat = runs + 1;
    end
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Counts cycles from the first cycle after accept until done (bounded).
  task automatic wait_done(output int k);
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [RW-1:0] exp_r, got;
    int lat, k;
    bit dz;
    model(op, a, b, exp_r, lat, dz);
    exp_q.push_back(exp_r);
    @(negedge clk);
    start = 1'b1; MDcon = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0; MDcon = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
    wait_done(k);
    exp_r = exp_q.pop_front();
    got = {Hi, Lo};
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL %s done_timeout: done=%b after %0d cycles", tag, done, k); end
    vectors++;
    if (k !== lat) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", tag, k, lat); end
    vectors++;
    if (got !== exp_r) begin miscompares++; $display("FAIL %s result: got %h expected %h", tag, got, exp_r); end
    vectors++;
    if (DivZ !== dz) begin miscompares++; $display("FAIL %s divz: got %b expected %b", tag, DivZ, dz); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_at_done: got %b expected 1", tag, busy); end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00 || {Hi, Lo} !== exp_r || DivZ !== dz) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b busy=%b result=%h divz=%b expected 0 0 %h %b",
               tag, done, busy, {Hi, Lo}, DivZ, exp_r, dz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, DivZ} !== 3'b000 || {Hi, Lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b divz=%b result=%h expected all zero", busy, done, DivZ, {Hi, Lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'h0000_63C0, 32'h0002_4A54, "multu_spec");
    run_op(2'b00, 32'hFFFF_FFF6, 32'h0000_0019, "mult_neg");
    run_op(2'b10, 32'hFFFF_FF9C, 32'h0000_0007, "div_neg");
    run_op(2'b11, 32'h0000_1212, 32'h0000_0000, "divu_zero");
    run_op(2'b11, 32'h0000_0064, 32'h0000_000A, "divu_after_zero");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1_m1");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(2'b01, 32'h0000_1234, 32'h0000_0001, "multu_by_one");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minint");
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, "div_pos_neg");
    run_op(2'b10, 32'h8000_0000, 32'h0000_0000, "div_zero");
    run_op(2'b11, 32'h0000_0064, 32'h0000_000A, "divu_plain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "random");
    end
  endtask

  // start held high through busy and done: only the cycle after done may accept.
  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [RW-1:0] e1, e2;
    int l1, l2, k;
    bit d1, d2;
    a1 = $urandom; b1 = $urandom | 32'h0000_0100;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    model(2'b01, a1, b1, e1, l1, d1);
    model(2'b10, a2, b2, e2, l2, d2);
    @(negedge clk);
    start = 1'b1; MDcon = 2'b01; SrcA = a1; SrcB = b1;
    @(negedge clk);
    MDcon = 2'b10; SrcA = a2; SrcB = b2;
    wait_done(k);
    vectors++;
    if (k !== l1 || {Hi, Lo} !== e1) begin
      miscompares++;
      $display("FAIL b2b_first: latency %0d result %h expected %0d %h", k, {Hi, Lo}, l1, e1);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || {Hi, Lo} !== e1) begin
      miscompares++;
      $display("FAIL b2b_gap: busy=%b done=%b result=%h expected 0 0 %h", busy, done, {Hi, Lo}, e1);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    vectors++;
    if (k !== l2 || {Hi, Lo} !== e2) begin
      miscompares++;
      $display("FAIL b2b_second: latency %0d result %h expected %0d %h", k, {Hi, Lo}, l2, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    start = 1'b1; MDcon = 2'b00; SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, DivZ} !== 3'b000 || {Hi, Lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b done=%b divz=%b result=%h expected all zero", busy, done, DivZ, {Hi, Lo});
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    run_op(2'b01, 32'h0000_0003, 32'h0000_0005, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
